// File: rtl/id_stage_reg.sv
// id_stage_reg: ID/EXE pipeline register with freeze hold, bubble insertion and
// saturating hazard/flush bubble counters.
module id_stage_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic        hazard,
    input  logic [31:0] pc_in,
    input  logic [31:0] val_rn_in,
    input  logic [31:0] val_rm_in,
    input  logic [3:0]  exe_cmd_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic        wb_en_in,
    input  logic        b_in,
    input  logic        s_in,
    input  logic        imm_in,
    input  logic [11:0] shift_operand_in,
    input  logic [23:0] signed_imm_24_in,
    input  logic [3:0]  dest_in,
    input  logic [3:0]  src1_in,
    input  logic [3:0]  src2_in,
    input  logic [3:0]  status_in,
    output logic [31:0] pc,
    output logic [31:0] val_rn,
    output logic [31:0] val_rm,
    output logic [3:0]  exe_cmd,
    output logic        exe_mem_r_en,
    output logic        mem_w_en,
    output logic        wb_en,
    output logic        b,
    output logic        s,
    output logic        imm,
    output logic [11:0] shift_operand,
    output logic [23:0] signed_imm_24,
    output logic [3:0]  exe_dest,
    output logic [3:0]  src1,
    output logic [3:0]  src2,
    output logic [3:0]  status,
    output logic        valid,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);
    localparam int W = 158;
    logic [W-1:0] q;
    logic         bubble;
    assign bubble = flush || hazard;
    // flush outranks hazard, so a combined request is charged to flush_cnt only
    always_ff @(posedge clk)
        if (rst) begin
            q         <= '0;
            valid     <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!freeze) begin
            q     <= bubble ? '0 : {pc_in, val_rn_in, val_rm_in, exe_cmd_in, mem_r_en_in, mem_w_en_in,
                                    wb_en_in, b_in, s_in, imm_in, shift_operand_in, signed_imm_24_in,
                                    dest_in, src1_in, src2_in, status_in};
            valid <= !bubble;
            if (flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
            if (!flush && hazard && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
        end
    assign {pc, val_rn, val_rm, exe_cmd, exe_mem_r_en, mem_w_en, wb_en, b, s, imm, shift_operand,
            signed_imm_24, exe_dest, src1, src2, status} = q;
endmodule
